// File: rtl/cmacc_pkg.sv
// Shared definitions for the interleaved complex multiply-accumulator:
// pipeline latency, width derivations and saturation limits.
package cmacc_pkg;

    // Input register to output register, in clock edges.
    localparam int LATENCY  = 5;

    // Widest accumulator the saturation limit helpers can describe.
    localparam int SAT_MAXW = 256;

    // Pre-adder result is one bit wider than its operands.
    function automatic int preadd_w(input int w);
        return w + 1;
    endfunction

    // Product of a pre-added operand with a plain operand of the other side.
    function automatic int prod_w(input int aw, input int bw);
        return aw + bw + 1;
    endfunction

    // Sum of two products, full precision.
    function automatic int sum_w(input int aw, input int bw);
        return aw + bw + 2;
    endfunction

    // Channel index width; at least one bit even for a single channel.
    function automatic int chw_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Largest positive value of a w-bit signed number (low w bits valid).
    function automatic logic [SAT_MAXW-1:0] sat_max_f(input int w);
        return (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1);
    endfunction

    // Most negative value of a w-bit signed number (low w bits valid).
    function automatic logic [SAT_MAXW-1:0] sat_min_f(input int w);
        return ~sat_max_f(w);
    endfunction

endpackage

// File: rtl/cmacc_nch_if.sv
// Sample/result bundle of cmacc_nch. The master drives samples and
// receives results; the slave (the accumulator) does the opposite.
interface cmacc_nch_if
    import cmacc_pkg::*;
#(
    parameter int AWIDTH  = 16,
    parameter int BWIDTH  = 18,
    parameter int SIZEOUT = 48,
    parameter int NCH     = 4
);
    localparam int CHW = chw_f(NCH);

    logic                      in_valid;
    logic                      sload;
    logic [CHW-1:0]            ch;
    logic signed [AWIDTH-1:0]  ar;
    logic signed [AWIDTH-1:0]  ai;
    logic signed [BWIDTH-1:0]  br;
    logic signed [BWIDTH-1:0]  bi;
    logic                      out_valid;
    logic [CHW-1:0]            out_ch;
    logic signed [SIZEOUT-1:0] pr;
    logic signed [SIZEOUT-1:0] pi;
    logic                      ovf;

    modport master (
        output in_valid, sload, ch, ar, ai, br, bi,
        input  out_valid, out_ch, pr, pi, ovf
    );

    modport slave (
        input  in_valid, sload, ch, ar, ai, br, bi,
        output out_valid, out_ch, pr, pi, ovf
    );

endinterface

// File: rtl/cmacc_sat_add.sv
// W-bit signed adder used for the accumulate step. With CMACC_SAT_EN
// defined the result clamps to the signed range and ovf flags the clamp;
// otherwise the sum wraps modulo 2^W and ovf is held at 0.
module cmacc_sat_add
    import cmacc_pkg::*;
#(
    parameter int W = 48
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y,
    output logic                ovf
);

    logic signed [W-1:0] sum;

    assign sum = a + b;

`ifdef CMACC_SAT_EN
    localparam logic signed [W-1:0] SMAX = W'(sat_max_f(W));
    localparam logic signed [W-1:0] SMIN = W'(sat_min_f(W));

    logic pos_ovf;
    logic neg_ovf;

    // Overflow only when both operands share a sign the sum does not.
    always_comb begin
        pos_ovf = !a[W-1] && !b[W-1] &&  sum[W-1];
        neg_ovf =  a[W-1] &&  b[W-1] && !sum[W-1];
        y       = sum;
        if (pos_ovf) begin
            y = SMAX;
        end else if (neg_ovf) begin
            y = SMIN;
        end
        ovf = pos_ovf | neg_ovf;
    end
`else
    assign y   = sum;
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/cmacc_nch.sv
// Interleaved complex multiply-accumulate, NCH independent channels.
// Five-stage pipeline: input register, pre-add, three multiplies,
// product sums, accumulate/output register. The accumulator bank is only
// touched in the last stage, so same-channel samples on consecutive
// cycles need no forwarding. Build option: CMACC_SAT_EN selects
// saturating accumulation (default: wrap, ovf always 0).
module cmacc_nch
    import cmacc_pkg::*;
#(
    parameter int AWIDTH  = 16,
    parameter int BWIDTH  = 18,
    parameter int SIZEOUT = 48,
    parameter int NCH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    cmacc_nch_if.slave bus
);

    localparam int CHW = chw_f(NCH);
    localparam int PAW = preadd_w(AWIDTH);
    localparam int PBW = preadd_w(BWIDTH);
    localparam int PW  = prod_w(AWIDTH, BWIDTH);
    localparam int SW  = sum_w(AWIDTH, BWIDTH);

    if (SIZEOUT < SW) begin : g_bad_sizeout
        $error("cmacc_nch: SIZEOUT must be at least AWIDTH+BWIDTH+2");
    end
    if (NCH < 1) begin : g_bad_nch
        $error("cmacc_nch: NCH must be at least 1");
    end

    // S1: registered inputs
    logic                      vld_p1_d, vld_p1_q;
    logic                      sload_p1_d, sload_p1_q;
    logic [CHW-1:0]            ch_p1_d, ch_p1_q;
    logic signed [AWIDTH-1:0]  ar_p1_d, ar_p1_q, ai_p1_d, ai_p1_q;
    logic signed [BWIDTH-1:0]  br_p1_d, br_p1_q, bi_p1_d, bi_p1_q;
    // S2: pre-adds plus the operands the multipliers still need
    logic                      vld_p2_d, vld_p2_q;
    logic                      sload_p2_d, sload_p2_q;
    logic [CHW-1:0]            ch_p2_d, ch_p2_q;
    logic signed [PAW-1:0]     ad_p2_d, ad_p2_q;
    logic signed [PBW-1:0]     bd_p2_d, bd_p2_q, bs_p2_d, bs_p2_q;
    logic signed [AWIDTH-1:0]  ar_p2_d, ar_p2_q, ai_p2_d, ai_p2_q;
    logic signed [BWIDTH-1:0]  bi_p2_d, bi_p2_q;
    // S3: products
    logic                      vld_p3_d, vld_p3_q;
    logic                      sload_p3_d, sload_p3_q;
    logic [CHW-1:0]            ch_p3_d, ch_p3_q;
    logic signed [PW-1:0]      mc_p3_d, mc_p3_q, mr_p3_d, mr_p3_q, mi_p3_d, mi_p3_q;
    // S4: complex product, already extended to accumulator width
    logic                      vld_p4_d, vld_p4_q;
    logic                      sload_p4_d, sload_p4_q;
    logic [CHW-1:0]            ch_p4_d, ch_p4_q;
    logic signed [SIZEOUT-1:0] sr_p4_d, sr_p4_q, si_p4_d, si_p4_q;
    // S5: accumulators and output register
    logic signed [SIZEOUT-1:0] acc_re_d [NCH];
    logic signed [SIZEOUT-1:0] acc_re_q [NCH];
    logic signed [SIZEOUT-1:0] acc_im_d [NCH];
    logic signed [SIZEOUT-1:0] acc_im_q [NCH];
    logic                      out_valid_d, out_valid_q;
    logic [CHW-1:0]            out_ch_d, out_ch_q;
    logic signed [SIZEOUT-1:0] pr_d, pr_q, pi_d, pi_q;
    logic                      ovf_d, ovf_q;

    logic                      ch_ok;
    logic signed [SIZEOUT-1:0] base_re, base_im;
    logic signed [SIZEOUT-1:0] sum_re, sum_im;
    logic                      ovf_re, ovf_im;

    // Datapath of S1..S4: capture, pre-add, multiply, sum products.
    always_comb begin
        vld_p1_d   = bus.in_valid;
        sload_p1_d = bus.sload;
        ch_p1_d    = bus.ch;
        ar_p1_d    = bus.ar;
        ai_p1_d    = bus.ai;
        br_p1_d    = bus.br;
        bi_p1_d    = bus.bi;

        vld_p2_d   = vld_p1_q;
        sload_p2_d = sload_p1_q;
        ch_p2_d    = ch_p1_q;
        ad_p2_d    = PAW'(ar_p1_q) - PAW'(ai_p1_q);
        bd_p2_d    = PBW'(br_p1_q) - PBW'(bi_p1_q);
        bs_p2_d    = PBW'(br_p1_q) + PBW'(bi_p1_q);
        ar_p2_d    = ar_p1_q;
        ai_p2_d    = ai_p1_q;
        bi_p2_d    = bi_p1_q;

        vld_p3_d   = vld_p2_q;
        sload_p3_d = sload_p2_q;
        ch_p3_d    = ch_p2_q;
        mc_p3_d    = PW'(ad_p2_q) * PW'(bi_p2_q);
        mr_p3_d    = PW'(bd_p2_q) * PW'(ar_p2_q);
        mi_p3_d    = PW'(bs_p2_q) * PW'(ai_p2_q);

        vld_p4_d   = vld_p3_q;
        sload_p4_d = sload_p3_q;
        ch_p4_d    = ch_p3_q;
        sr_p4_d    = SIZEOUT'(mc_p3_q) + SIZEOUT'(mr_p3_q);
        si_p4_d    = SIZEOUT'(mc_p3_q) + SIZEOUT'(mi_p3_q);
    end

    // S5 accumulate base: zero on sload or an out-of-range channel.
    always_comb begin
        ch_ok   = (32'(ch_p4_q) < 32'(NCH));
        base_re = '0;
        base_im = '0;
        if (!sload_p4_q && ch_ok) begin
            base_re = acc_re_q[ch_p4_q];
            base_im = acc_im_q[ch_p4_q];
        end
    end

    cmacc_sat_add #(.W(SIZEOUT)) u_add_re (
        .a   (base_re),
        .b   (sr_p4_q),
        .y   (sum_re),
        .ovf (ovf_re)
    );

    cmacc_sat_add #(.W(SIZEOUT)) u_add_im (
        .a   (base_im),
        .b   (si_p4_q),
        .y   (sum_im),
        .ovf (ovf_im)
    );

    // S5 write-back: results update only on a valid sample, else hold.
    always_comb begin
        acc_re_d    = acc_re_q;
        acc_im_d    = acc_im_q;
        out_valid_d = vld_p4_q;
        out_ch_d    = out_ch_q;
        pr_d        = pr_q;
        pi_d        = pi_q;
        ovf_d       = ovf_q;
        if (vld_p4_q) begin
            out_ch_d = ch_p4_q;
            pr_d     = sum_re;
            pi_d     = sum_im;
            ovf_d    = ovf_re | ovf_im;
            if (ch_ok) begin
                acc_re_d[ch_p4_q] = sum_re;
                acc_im_d[ch_p4_q] = sum_im;
            end
        end
    end

    // Valids, accumulators and outputs: cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            vld_p3_q    <= 1'b0;
            vld_p4_q    <= 1'b0;
            acc_re_q    <= '{default: '0};
            acc_im_q    <= '{default: '0};
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            pr_q        <= '0;
            pi_q        <= '0;
            ovf_q       <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            vld_p3_q    <= vld_p3_d;
            vld_p4_q    <= vld_p4_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            pr_q        <= pr_d;
            pi_q        <= pi_d;
            ovf_q       <= ovf_d;
        end
    end

    // Pipeline payload: qualified by the valids, so no reset needed.
    always_ff @(posedge clk) begin
        sload_p1_q <= sload_p1_d;
        ch_p1_q    <= ch_p1_d;
        ar_p1_q    <= ar_p1_d;
        ai_p1_q    <= ai_p1_d;
        br_p1_q    <= br_p1_d;
        bi_p1_q    <= bi_p1_d;
        sload_p2_q <= sload_p2_d;
        ch_p2_q    <= ch_p2_d;
        ad_p2_q    <= ad_p2_d;
        bd_p2_q    <= bd_p2_d;
        bs_p2_q    <= bs_p2_d;
        ar_p2_q    <= ar_p2_d;
        ai_p2_q    <= ai_p2_d;
        bi_p2_q    <= bi_p2_d;
        sload_p3_q <= sload_p3_d;
        ch_p3_q    <= ch_p3_d;
        mc_p3_q    <= mc_p3_d;
        mr_p3_q    <= mr_p3_d;
        mi_p3_q    <= mi_p3_d;
        sload_p4_q <= sload_p4_d;
        ch_p4_q    <= ch_p4_d;
        sr_p4_q    <= sr_p4_d;
        si_p4_q    <= si_p4_d;
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.pr        = pr_q;
    assign bus.pi        = pi_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: doc/cmacc_nch.md
CMACC_NCH -- requirements
Module: cmacc_nch

Interface
REQ-001 Parameter AWIDTH, default 16: signed width of the ar and ai inputs.
REQ-002 Parameter BWIDTH, default 18: signed width of the br and bi inputs.
REQ-003 Parameter SIZEOUT, default 48: signed accumulator and output width; SHALL be at least AWIDTH+BWIDTH+2, with an elaboration error otherwise.
REQ-004 Parameter NCH, default 4: number of independent interleaved accumulator channels; SHALL be at least 1. CHW = max(1, clog2(NCH)).
REQ-005 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 in_valid  in  1  qualifies the input sample.
REQ-008 sload  in  1  when set, restarts accumulation of this channel with the current product.
REQ-009 ch  in  CHW  channel index of the sample; values at or above NCH are invalid input.
REQ-010 ar, ai  in  AWIDTH  signed operand a.
REQ-011 br, bi  in  BWIDTH  signed operand b.
REQ-012 out_valid  out  1  qualifies pr, pi, out_ch and ovf.
REQ-013 out_ch  out  CHW  channel of the result.
REQ-014 pr, pi  out  SIZEOUT  signed accumulated real and imaginary results.
REQ-015 ovf  out  1  saturation occurred on this result.

Function
REQ-016 Per valid sample, the block SHALL compute acc[ch] = (sload ? 0 : acc[ch]) + (ar+i*ai)*(br+i*bi), separately for the real and imaginary parts.
REQ-017 Products SHALL use the three-multiplier form: common=(ar-ai)*bi, real=common+(br-bi)*ar, imag=common+(br+bi)*ai.
REQ-018 Arithmetic width rules:
- Pre-adders SHALL be one bit wider than their operands.
- Products and sums SHALL be sign-extended to SIZEOUT before accumulation.
- There SHALL be no intermediate truncation.
REQ-019 Pipeline stages:
- S1: register the inputs.
- S2: pre-add.
- S3: three multiplies.
- S4: product sums.
- S5: accumulate and register the outputs.
REQ-020 out_valid SHALL assert exactly 5 cycles after the corresponding in_valid; sload and ch SHALL travel with the data.
REQ-021 Every stage SHALL carry its own valid bit; bubbles (in_valid=0) SHALL not modify any accumulator.
REQ-022 Same-channel samples on consecutive cycles SHALL accumulate correctly, with no stall and no hazard.
- The accumulator SHALL be read and written within S5 only.
REQ-023 pr, pi, out_ch and ovf SHALL hold their last value while out_valid=0.
REQ-024 A sample with ch >= NCH SHALL propagate out_valid, SHALL output the unaccumulated product, and SHALL not write any accumulator.
REQ-025 Without saturation, accumulator overflow SHALL wrap modulo 2^SIZEOUT, and ovf SHALL stay 0.
REQ-026 The input has no backpressure: a sample SHALL be accepted on every cycle.

Reset
REQ-027 While rst=1, the block SHALL clear the following to 0: all stage valids, all accumulators, out_valid, pr, pi, out_ch and ovf.
REQ-028 Samples in flight when rst asserts SHALL be discarded.
REQ-029 Samples presented while rst=1 SHALL be ignored.
REQ-030 The first sample accepted after reset release SHALL accumulate from 0, regardless of sload.

Configuration
REQ-031 The macro CMACC_SAT_EN SHALL select saturating accumulation.
- Defined: each S5 sum that overflows SHALL clamp to +(2^(SIZEOUT-1)-1) or -2^(SIZEOUT-1).
- Defined: the clamped value SHALL be stored in the accumulator.
- Defined: ovf=1 for that result, evaluated per part and ORed.
- Undefined: wrap behaviour per REQ-025, and ovf tied to 0.

Structure
REQ-032 A package cmacc_pkg SHALL hold the shared definitions:
- the pipeline latency constant (5);
- the width-derivation functions (pre-add width, product width, CHW);
- saturation limit functions parameterised by width.
REQ-033 One sub-module, cmacc_sat_add, SHALL implement the SIZEOUT-wide signed add with wrap or saturate and the overflow flag.
- It SHALL be instantiated twice, once for the real part and once for the imaginary part.

Verification
REQ-034 A bench SHALL cover these directed scenarios at the default parameters:
- Single sample: ch=0, sload=1, a=3+i4, b=5-i2 -> 5 cycles later out_valid=1, out_ch=0, pr=23, pi=14.
- Accumulation: the same sample 3 times back-to-back on ch=1, only the first with sload=1 -> pr=23,46,69 and pi=14,28,42 on consecutive cycles.
- Interleave: samples alternating ch0/ch2 with a=1, b=1, and sload on the first of each -> each channel reads pr=1,2,3 independently; ch1 and ch3 accumulators remain 0.
- Reset mid-stream: rst=1 for one cycle with 3 samples in flight -> no out_valid for those samples; the next sample with sload=0 returns its bare product.
- Overflow at SIZEOUT=36, AWIDTH=16, BWIDTH=18: repeat ar=-32768, br=-131072 with zero imaginary parts -> with CMACC_SAT_EN, pr clamps at 2^35-1 with ovf=1; without it, pr wraps negative with ovf=0.
